// File: rtl/if_prefetch_stage.sv
// Instruction-fetch stage with a decoupling prefetch FIFO.
// Sequential fetch addresses go out on a split request/response memory
// port, with up to MAX_OUT requests in flight. Returned instructions are
// queued in a DEPTH-entry FIFO that the ID stage drains under freeze.
// A taken branch flushes the FIFO, redirects fetch, and marks every
// still-pending request so that its response is discarded on return.
//
// Handshakes:
//   imem: a request is accepted in a cycle where imem_req & imem_gnt;
//         imem_addr is only meaningful in that cycle. Responses return
//         in request order, one per imem_rvalid pulse. An rvalid while
//         nothing is outstanding is ignored.
//   ID:   the head entry is consumed in a cycle where Ins_valid & ~freeze.
module if_prefetch_stage #(
    parameter int                ADDR_W   = 32,
    parameter int                INS_W    = 32,
    parameter int                PC_STEP  = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                DEPTH    = 4,
    parameter int                MAX_OUT  = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              freeze,
    input  logic              Branch_taken,
    input  logic [ADDR_W-1:0] Branch_Address,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_gnt,
    input  logic              imem_rvalid,
    input  logic [INS_W-1:0]  imem_rdata,
    output logic              Ins_valid,
    output logic [ADDR_W-1:0] PC_ID_Stage_Reg,
    output logic [INS_W-1:0]  Ins
);

    // Pointer width and a counter width wide enough to hold
    // count + live outstanding (at most DEPTH + MAX_OUT <= 2*DEPTH).
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1) + 1;

    localparam logic [CW-1:0]     DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0]     MAXO_C  = CW'(MAX_OUT);
    localparam logic [ADDR_W-1:0] STEP_C  = ADDR_W'(PC_STEP);

    // Architectural state
    logic [ADDR_W-1:0] r_fpc;        // next address to request
    logic [ADDR_W-1:0] r_epc;        // address of the next accepted response
    logic [CW-1:0]     r_count;      // FIFO occupancy
    logic [CW-1:0]     r_out_cnt;    // requests accepted, response not yet seen
    logic [CW-1:0]     r_drop_cnt;   // outstanding responses to discard
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;

    // FIFO storage; each entry holds the PC of the following instruction
    // alongside the instruction word.
    logic [ADDR_W-1:0] r_pc_mem  [DEPTH];
    logic [INS_W-1:0]  r_ins_mem [DEPTH];

    logic [CW-1:0] w_live;
    logic          w_credit_ok;
    logic          w_req;
    logic          w_accept;
    logic          w_resp;
    logic          w_push;
    logic          w_pop;

    // Requests still owed to the FIFO (stale ones are excluded); a new
    // request is only issued if its response is guaranteed a FIFO slot.
    assign w_live      = r_out_cnt - r_drop_cnt;
    assign w_credit_ok = (r_count + w_live) < DEPTH_C;
    assign w_req       = rst_n & ~Branch_taken & (r_out_cnt < MAXO_C) & w_credit_ok;
    assign w_accept    = w_req & imem_gnt;

    // A response only counts when something is outstanding; it is kept
    // unless it belongs to a pre-branch request or a branch is happening now.
    assign w_resp = imem_rvalid & (r_out_cnt != '0);
    assign w_push = w_resp & (r_drop_cnt == '0) & ~Branch_taken;
    assign w_pop  = (r_count != '0) & ~freeze & ~Branch_taken;

    assign imem_req  = w_req;
    assign imem_addr = r_fpc;

    // Head of the FIFO, forced to zero when empty
    assign Ins_valid       = (r_count != '0);
    assign PC_ID_Stage_Reg = Ins_valid ? r_pc_mem[r_rd_ptr]  : '0;
    assign Ins             = Ins_valid ? r_ins_mem[r_rd_ptr] : '0;

    // Control state: branch redirect has priority over all other updates
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_fpc      <= RESET_PC;
            r_epc      <= RESET_PC;
            r_count    <= '0;
            r_out_cnt  <= '0;
            r_drop_cnt <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else if (Branch_taken) begin
            // No request can be accepted this cycle, so everything still
            // outstanding after this cycle's response is stale.
            r_fpc      <= Branch_Address;
            r_epc      <= Branch_Address;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_out_cnt  <= r_out_cnt - CW'(w_resp);
            r_drop_cnt <= r_out_cnt - CW'(w_resp);
        end else begin
            if (w_accept) begin
                r_fpc <= r_fpc + STEP_C;
            end
            if (w_push) begin
                r_epc    <= r_epc + STEP_C;
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            if (w_resp && (r_drop_cnt != '0)) begin
                r_drop_cnt <= r_drop_cnt - CW'(1);
            end
            r_count   <= r_count + CW'(w_push) - CW'(w_pop);
            r_out_cnt <= r_out_cnt + CW'(w_accept) - CW'(w_resp);
        end
    end

    // FIFO write port; contents need no reset because occupancy gates reads
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_pc_mem[r_wr_ptr]  <= r_epc + STEP_C;
            r_ins_mem[r_wr_ptr] <= imem_rdata;
        end
    end

endmodule

// File: tb/tb_if_prefetch_stage.sv
// Bench for if_prefetch_stage: an in-order memory model with random
// latency answers accepted fetches; every response that belongs to the
// current fetch stream adds one expected {pc+4, mem[pc]} entry, and a
// separate monitor checks each entry the ID side consumes.
module tb_if_prefetch_stage;

    localparam int          AW       = 32;
    localparam int          IW       = 32;
    localparam int          STEP     = 4;
    localparam logic [31:0] RESET_PC = 32'h0;
    localparam int          DEPTH    = 4;
    localparam int          MAX_OUT  = 2;

    logic          clk;
    logic          rst_n;
    logic          freeze;
    logic          Branch_taken;
    logic [AW-1:0] Branch_Address;
    logic          imem_req;
    logic [AW-1:0] imem_addr;
    logic          imem_gnt;
    logic          imem_rvalid;
    logic [IW-1:0] imem_rdata;
    logic          Ins_valid;
    logic [AW-1:0] PC_ID_Stage_Reg;
    logic [IW-1:0] Ins;

    if_prefetch_stage #(
        .ADDR_W  (AW),
        .INS_W   (IW),
        .PC_STEP (STEP),
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH),
        .MAX_OUT (MAX_OUT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .freeze         (freeze),
        .Branch_taken   (Branch_taken),
        .Branch_Address (Branch_Address),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .Ins_valid      (Ins_valid),
        .PC_ID_Stage_Reg(PC_ID_Stage_Reg),
        .Ins            (Ins)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model state ----------------
    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          ready;
    } mreq_t;

    mreq_t       mq[$];          // accepted requests awaiting a response
    logic [63:0] exp_q[$];       // expected {pc, ins} entries in FIFO order
    logic [31:0] m_fpc;          // next fetch address the stream should use
    int          m_epoch;        // bumped on every branch / reset
    bit          flushed;        // previous cycle was a branch
    bit          rel_pending;    // release reset at next step
    bit          br_on_rv;       // test 5: branch on a qualifying rvalid

    int          n_vec;
    int          n_err;
    int          cyc;
    int          n_accept;
    logic [31:0] last_acc_addr;
    bit          obs_req;
    logic [31:0] obs_addr;
    bit          obs_valid;
    logic [31:0] obs_pc;
    logic [31:0] obs_ins;
    bit          last_br;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return a ^ 32'hC0DE_0000;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- driver: one clock cycle ----------------
    task automatic step(input bit br, input logic [31:0] tgt, input bit frz,
                        input bit gnt, input int lat);
        bit    rv;
        bit    acc;
        int    live;
        mreq_t e;
        @(negedge clk);
        cyc++;
        if (rel_pending) begin
            rst_n       = 1'b1;
            rel_pending = 1'b0;
        end
        rv = (mq.size() != 0) && (mq[0].ready <= cyc);
        if (br_on_rv) br = rv && (mq.size() == 2) && (exp_q.size() >= 2);
        freeze         = frz;
        Branch_taken   = br;
        Branch_Address = tgt;
        imem_gnt       = gnt;
        imem_rvalid    = rv;
        imem_rdata     = rv ? mem_word(mq[0].addr) : $urandom();
        #1;
        obs_req   = imem_req;
        obs_addr  = imem_addr;
        obs_valid = Ins_valid;
        obs_pc    = PC_ID_Stage_Reg;
        obs_ins   = Ins;
        last_br   = br;
        if (!rst_n) check("req_in_reset", imem_req, 0);
        if (br) check("req_in_branch", imem_req, 0);
        acc = imem_req && gnt;
        if (acc) begin
            live = 0;
            foreach (mq[i]) if (mq[i].epoch == m_epoch) live++;
            check("fetch_addr", imem_addr, m_fpc);
            check("outstanding_limit", mq.size() < MAX_OUT, 1);
            check("credit_limit", (exp_q.size() + live) < DEPTH, 1);
            n_accept++;
            last_acc_addr = imem_addr;
        end
        #2;  // monitor has looked at this cycle's head by now
        if (rv) begin
            e = mq.pop_front();
            if (rst_n && !br && e.epoch == m_epoch)
                exp_q.push_back({e.addr + 32'(STEP), mem_word(e.addr)});
        end
        if (acc) begin
            mq.push_back('{obs_addr, m_epoch, cyc + lat});
            m_fpc += 32'(STEP);
        end
        flushed = br;
        if (br) begin
            exp_q.delete();
            m_epoch++;
            m_fpc = tgt;
        end
    endtask

    // Drain with no new grants until memory and FIFO are empty
    task automatic drain(input string name);
        int g;
        g = 0;
        while ((mq.size() != 0 || exp_q.size() != 0) && g < 40) begin
            step(0, 0, 0, 0, 1);
            g++;
        end
        check(name, g >= 40, 0);
    endtask

    // Asynchronous reset in the middle of a cycle
    task automatic do_reset();
        int g;
        #1;
        rst_n = 1'b0;
        #1;
        check("rst_req", imem_req, 0);
        check("rst_valid", Ins_valid, 0);
        check("rst_pc", PC_ID_Stage_Reg, 0);
        check("rst_ins", Ins, 0);
        check("rst_addr", imem_addr, RESET_PC);
        exp_q.delete();
        m_epoch++;
        m_fpc   = RESET_PC;
        flushed = 1'b0;
        step(0, 0, 0, 0, 1);
        rel_pending = 1'b1;
        g = 0;
        // stale responses may still arrive after release; they must be ignored
        do begin
            step(0, 0, 0, 0, 1);
            g++;
        end while (mq.size() != 0 && g < 20);
        check("rst_stale_drain", g >= 20, 0);
    endtask

    // ---------------- monitor / scoreboard ----------------
    always @(negedge clk) begin
        logic [63:0] x;
        #2;
        if (rst_n && !Branch_taken) begin
            if (flushed) check("empty_after_flush", Ins_valid, 0);
            check("ins_valid", Ins_valid, exp_q.size() != 0);
            if (!Ins_valid) begin
                check("pc_when_empty", PC_ID_Stage_Reg, 0);
                check("ins_when_empty", Ins, 0);
            end else if (!freeze && exp_q.size() != 0) begin
                x = exp_q.pop_front();
                check("head_pc", PC_ID_Stage_Reg, x[63:32]);
                check("head_ins", Ins, x[31:0]);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        bit          v[12];
        int          g;
        int          a0;
        logic [31:0] addr0;

        n_vec = 0; n_err = 0; cyc = 0; n_accept = 0;
        m_fpc = RESET_PC; m_epoch = 0; flushed = 0; rel_pending = 0; br_on_rv = 0;
        rst_n = 1'b0; freeze = 0; Branch_taken = 0; Branch_Address = '0;
        imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
        #3;
        check("init_req", imem_req, 0);
        check("init_valid", Ins_valid, 0);
        check("init_pc", PC_ID_Stage_Reg, 0);
        check("init_ins", Ins, 0);
        check("init_addr", imem_addr, RESET_PC);
        repeat (2) step(0, 0, 0, 0, 1);

        // 1: streaming, latency 1, no freeze
        rel_pending = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step(0, 0, 0, 1, 1);
            v[i] = obs_valid;
        end
        check("t1_lat_c0", v[0], 0);
        check("t1_lat_c1", v[1], 0);
        check("t1_lat_c2", v[2], 1);
        for (int i = 3; i < 12; i++) check("t1_no_bubble", v[i], 1);

        // 2: freeze from start fills exactly DEPTH entries
        do_reset();
        a0 = n_accept;
        for (int i = 0; i < 12; i++) step(0, 0, 1, 1, 1);
        check("t2_accepts", n_accept - a0, DEPTH);
        check("t2_req_stalled", obs_req, 0);
        check("t2_head_pc", obs_pc, RESET_PC + 32'(STEP));
        check("t2_head_ins", obs_ins, mem_word(RESET_PC));
        a0 = n_accept;
        g = 0;
        while (n_accept == a0 && g < 20) begin step(0, 0, 0, 1, 1); g++; end
        check("t2_resume_addr", last_acc_addr, RESET_PC + 32'(DEPTH * STEP));
        repeat (8) step(0, 0, 0, 1, 1);

        // 3: branch with two requests in flight
        g = 0;
        while (mq.size() != 2 && g < 30) begin step(0, 0, 0, 1, 4); g++; end
        check("t3_setup", g >= 30, 0);
        step(1, 32'h100, 0, 1, 4);
        a0 = n_accept;
        g = 0;
        while (n_accept == a0 && g < 30) begin step(0, 0, 0, 1, 1); g++; end
        check("t3_target_addr", last_acc_addr, 32'h100);
        g = 0;
        while (!obs_valid && g < 30) begin step(0, 0, 0, 1, 1); g++; end
        check("t3_first_pc", obs_pc, 32'h104);
        check("t3_first_ins", obs_ins, mem_word(32'h100));

        // 4: grant withheld for three cycles
        drain("t4_drain");
        step(0, 0, 0, 0, 1);
        addr0 = obs_addr;
        for (int i = 0; i < 3; i++) begin
            step(0, 0, 0, 0, 1);
            check("t4_req_held", obs_req, 1);
            check("t4_addr_held", obs_addr, addr0);
        end
        a0 = n_accept;
        step(0, 0, 0, 1, 1);
        check("t4_accept", n_accept - a0, 1);
        check("t4_accept_addr", last_acc_addr, addr0);
        step(0, 0, 0, 0, 1);
        check("t4_addr_adv", obs_addr, addr0 + 32'(STEP));

        // 5: branch coincident with rvalid while frozen with a filled FIFO
        drain("t5_drain");
        br_on_rv = 1'b1;
        g = 0;
        last_br = 1'b0;
        while (!last_br && g < 40) begin step(0, 32'h2000, 1, 1, 3); g++; end
        br_on_rv = 1'b0;
        check("t5_branch_seen", last_br, 1);
        step(0, 0, 1, 1, 3);
        check("t5_valid_after", obs_valid, 0);
        repeat (10) step(0, 0, 0, 1, 2);

        // 6: reset with two requests outstanding
        g = 0;
        while (mq.size() != 2 && g < 30) begin step(0, 0, 0, 1, 3); g++; end
        check("t6_setup", g >= 30, 0);
        do_reset();
        a0 = n_accept;
        g = 0;
        while (n_accept == a0 && g < 20) begin step(0, 0, 0, 1, 1); g++; end
        check("t6_restart_addr", last_acc_addr, RESET_PC);

        // Random phase, starting near the top of the address space
        step(1, 32'hFFFF_FFF0, 0, 1, 1);
        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 99) < 3, $urandom() & 32'hFFFF_FFFC,
                 $urandom_range(0, 99) < 30, $urandom_range(0, 99) < 70,
                 $urandom_range(1, 4));
            if ($urandom_range(0, 499) == 0) do_reset();
        end

        drain("final_drain");
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
